// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard/stall scheduler: FSM state
// encodings, stall-vector bit positions and the canonical stall masks.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_REDIRECT = 2'd2
    } state_e;

    localparam int STALL_W        = 6;
    localparam int STALL_BIT_PC    = 0;
    localparam int STALL_BIT_IF_ID = 1;
    localparam int STALL_BIT_ID_EX = 2;
    localparam int STALL_BIT_EX_MEM = 3;
    localparam int STALL_BIT_MEM_WB = 4;
    localparam int STALL_BIT_RSVD  = 5;

    // Memory stall freezes everything up to and including MEM/WB.
    localparam logic [STALL_W-1:0] STALL_MEM = 6'b011111;
    // Load-use holds PC, IF/ID and ID/EX while a bubble is injected into EX.
    localparam logic [STALL_W-1:0] STALL_LU  = 6'b000111;
    // Fetch stall only holds the front end.
    localparam logic [STALL_W-1:0] STALL_IF  = 6'b000011;

    // True when a read port is enabled and addresses the given register.
    function automatic logic port_hits(input logic       rd_en,
                                       input logic [4:0] rd_addr,
                                       input logic [4:0] ex_addr);
        return rd_en && (rd_addr == ex_addr);
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the hazard scheduler performance counters.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;

    // Count up on inc, holding once the all-ones value is reached.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall scheduler for the 5-stage RV32I core.
// Arbitrates memory/fetch stalls, load-use bubbles and EX mispredict
// redirects into one stall vector, flush strobes and a PC redirect.
// All control outputs are combinational; state, the pending redirect and
// the performance counters are registered.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_reg1_read,
    input  logic [4:0]       id_reg1_addr,
    input  logic             id_reg2_read,
    input  logic [4:0]       id_reg2_addr,
    input  logic             ex_is_load,
    input  logic             ex_rd_enable,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_mispredict,
    input  logic [31:0]      ex_target,
    input  logic             if_stall_req,
    input  logic             mem_stall_req,
    output logic [5:0]       stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic [CNT_W-1:0] cnt_mem_stall,
    output logic [CNT_W-1:0] cnt_load_use,
    output logic [CNT_W-1:0] cnt_redirect
);

    state_e      state_q, state_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;

    logic [5:0]  stall_c;
    logic        flush_if_id_c, flush_id_ex_c, redirect_valid_c;
    logic [31:0] redirect_pc_c;
    logic        load_use_fire;
    logic        load_use_hazard;

    // A load in EX writing a non-zero rd that an ID read port consumes.
    assign load_use_hazard = ex_is_load && ex_rd_enable && (ex_rd_addr != 5'd0) &&
                             (port_hits(id_reg1_read, id_reg1_addr, ex_rd_addr) ||
                              port_hits(id_reg2_read, id_reg2_addr, ex_rd_addr));

    // Priority arbitration: memory stall, then redirect, then load-use, then fetch stall.
    always_comb begin
        // NOTE: every signal gets a default before the if-chain so no path
        // leaves one unassigned and no latch is inferred.
        state_d          = state_q;
        pend_valid_d     = pend_valid_q;
        pend_pc_d        = pend_pc_q;
        stall_c          = '0;
        flush_if_id_c    = 1'b0;
        flush_id_ex_c    = 1'b0;
        redirect_valid_c = 1'b0;
        redirect_pc_c    = '0;
        load_use_fire    = 1'b0;

        if (mem_stall_req) begin
            stall_c = STALL_MEM;
            state_d = ST_MEM_WAIT;
            // EX holds a flushed NOP in REDIRECT, so its mispredict is meaningless.
            // Only the first report is kept; EX is frozen so later ones repeat it.
            if (ex_mispredict && (state_q != ST_REDIRECT) && !pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = ex_target;
            end
        end else if (pend_valid_q || (ex_mispredict && (state_q == ST_RUN))) begin
            redirect_valid_c = 1'b1;
            flush_if_id_c    = 1'b1;
            flush_id_ex_c    = 1'b1;
            redirect_pc_c    = pend_valid_q ? pend_pc_q : ex_target;
            pend_valid_d     = 1'b0;
            state_d          = ST_REDIRECT;
        end else begin
            state_d = ST_RUN;
            if (load_use_hazard && (state_q != ST_REDIRECT)) begin
                stall_c       = STALL_LU;
                flush_id_ex_c = 1'b1;
                load_use_fire = 1'b1;
            end else if (if_stall_req) begin
                stall_c = STALL_IF;
            end
        end

        stall_c[STALL_BIT_RSVD] = 1'b0;
    end

    // FSM state and pending-redirect registers; reset discards any pending target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

    // Controls are forced quiet for as long as reset is held.
    assign stall          = rst ? stall_c          : '0;
    assign flush_if_id    = rst ? flush_if_id_c    : 1'b0;
    assign flush_id_ex    = rst ? flush_id_ex_c    : 1'b0;
    assign redirect_valid = rst ? redirect_valid_c : 1'b0;
    assign redirect_pc    = rst ? redirect_pc_c    : '0;

    sat_counter #(.W(CNT_W)) u_cnt_mem_stall (
        .clk   (clk),
        .rst_n (rst),
        .inc   (mem_stall_req),
        .cnt   (cnt_mem_stall)
    );

    sat_counter #(.W(CNT_W)) u_cnt_load_use (
        .clk   (clk),
        .rst_n (rst),
        .inc   (load_use_fire),
        .cnt   (cnt_load_use)
    );

    sat_counter #(.W(CNT_W)) u_cnt_redirect (
        .clk   (clk),
        .rst_n (rst),
        .inc   (redirect_valid_c),
        .cnt   (cnt_redirect)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus randomized
// traffic compared against a behavioural model of the scheduling rules.
// A second instance with 4-bit counters exercises saturation.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_reg1_read, id_reg2_read;
    logic [4:0]  id_reg1_addr, id_reg2_addr;
    logic        ex_is_load, ex_rd_enable, ex_mispredict;
    logic [4:0]  ex_rd_addr;
    logic [31:0] ex_target;
    logic        if_stall_req, mem_stall_req;

    logic [5:0]  stall;
    logic        flush_if_id, flush_id_ex, redirect_valid;
    logic [31:0] redirect_pc;
    logic [15:0] cnt_mem_stall, cnt_load_use, cnt_redirect;

    logic [5:0]  s_stall;
    logic        s_flush_if_id, s_flush_id_ex, s_redirect_valid;
    logic [31:0] s_redirect_pc;
    logic [3:0]  s_cnt_mem_stall, s_cnt_load_use, s_cnt_redirect;

    int checks = 0;
    int errors = 0;

    // Model: what happened last cycle, and the remembered redirect target.
    bit          m_prev_mem, m_prev_redir;
    logic [31:0] m_pend[$];
    int          m_cnt_mem, m_cnt_lu, m_cnt_red;
    int          m_cnt_mem4, m_cnt_lu4, m_cnt_red4;

    // Expected outputs for the current cycle.
    logic [5:0]  e_stall;
    logic        e_fii, e_fie, e_rv, e_lu;
    logic [31:0] e_pc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
        .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
        .ex_is_load(ex_is_load), .ex_rd_enable(ex_rd_enable), .ex_rd_addr(ex_rd_addr),
        .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .cnt_mem_stall(cnt_mem_stall), .cnt_load_use(cnt_load_use), .cnt_redirect(cnt_redirect)
    );

    hazard_ctrl #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst),
        .id_reg1_read(id_reg1_read), .id_reg1_addr(id_reg1_addr),
        .id_reg2_read(id_reg2_read), .id_reg2_addr(id_reg2_addr),
        .ex_is_load(ex_is_load), .ex_rd_enable(ex_rd_enable), .ex_rd_addr(ex_rd_addr),
        .ex_mispredict(ex_mispredict), .ex_target(ex_target),
        .if_stall_req(if_stall_req), .mem_stall_req(mem_stall_req),
        .stall(s_stall), .flush_if_id(s_flush_if_id), .flush_id_ex(s_flush_id_ex),
        .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
        .cnt_mem_stall(s_cnt_mem_stall), .cnt_load_use(s_cnt_load_use), .cnt_redirect(s_cnt_redirect)
    );

    function automatic int sat_inc(input int v, input bit inc, input int max);
        return (inc && v < max) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_prev_mem   = 1'b0;
        m_prev_redir = 1'b0;
        m_pend.delete();
        m_cnt_mem = 0; m_cnt_lu = 0; m_cnt_red = 0;
        m_cnt_mem4 = 0; m_cnt_lu4 = 0; m_cnt_red4 = 0;
    endtask

    task automatic idle_inputs();
        id_reg1_read = 0; id_reg1_addr = 0; id_reg2_read = 0; id_reg2_addr = 0;
        ex_is_load = 0; ex_rd_enable = 0; ex_rd_addr = 0;
        ex_mispredict = 0; ex_target = 0;
        if_stall_req = 0; mem_stall_req = 0;
    endtask

    // Derive this cycle's controls from the scheduling rules.
    task automatic compute_expected();
        bit haz;
        haz = ex_is_load && ex_rd_enable && (ex_rd_addr != 0) &&
              ((id_reg1_read && id_reg1_addr == ex_rd_addr) ||
               (id_reg2_read && id_reg2_addr == ex_rd_addr));
        e_stall = 0; e_fii = 0; e_fie = 0; e_rv = 0; e_pc = 0; e_lu = 0;
        if (!rst) return;
        if (mem_stall_req) begin
            e_stall = 6'b011111;
        end else if (m_pend.size() > 0 || (ex_mispredict && !m_prev_mem && !m_prev_redir)) begin
            e_rv = 1; e_fii = 1; e_fie = 1;
            e_pc = (m_pend.size() > 0) ? m_pend[0] : ex_target;
        end else if (haz && !m_prev_redir) begin
            e_stall = 6'b000111; e_fie = 1; e_lu = 1;
        end else if (if_stall_req) begin
            e_stall = 6'b000011;
        end
    endtask

    // Inputs are settled; compute expectations and move to the sampling point.
    task automatic apply();
        compute_expected();
        @(negedge clk);
    endtask

    // Clock edge: advance the model with the same inputs, sample after the edge.
    task automatic tick();
        @(posedge clk);
        if (!rst) begin
            model_reset();
        end else begin
            if (mem_stall_req && ex_mispredict && !m_prev_redir && m_pend.size() == 0)
                m_pend.push_back(ex_target);
            if (e_rv) m_pend.delete();
            m_cnt_mem  = sat_inc(m_cnt_mem,  mem_stall_req, 65535);
            m_cnt_lu   = sat_inc(m_cnt_lu,   e_lu, 65535);
            m_cnt_red  = sat_inc(m_cnt_red,  e_rv, 65535);
            m_cnt_mem4 = sat_inc(m_cnt_mem4, mem_stall_req, 15);
            m_cnt_lu4  = sat_inc(m_cnt_lu4,  e_lu, 15);
            m_cnt_red4 = sat_inc(m_cnt_red4, e_rv, 15);
            m_prev_mem   = mem_stall_req;
            m_prev_redir = e_rv;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle_inputs();
        ex_mispredict = 1; ex_target = 32'hDEAD_BEE0; mem_stall_req = 1;
        model_reset();
        #3;
        checks++;
        if ({stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc} !== 41'd0) begin
            errors++;
            $display("FAIL reset_outputs: got stall=%b fii=%b fie=%b rv=%b pc=%h, want all 0",
                     stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc);
        end
        @(posedge clk); #1;
        checks++;
        if ({cnt_mem_stall, cnt_load_use, cnt_redirect} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d %0d, want 0 0 0",
                     cnt_mem_stall, cnt_load_use, cnt_redirect);
        end
        idle_inputs();
        rst = 1;
    endtask

    task automatic test_load_use();
        idle_inputs();
        ex_is_load = 1; ex_rd_enable = 1; ex_rd_addr = 5;
        id_reg2_read = 1; id_reg2_addr = 5;
        apply();
        checks++;
        if ({stall, flush_if_id, flush_id_ex} !== {6'b000111, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL load_use_ctrl: got stall=%b fii=%b fie=%b, want 000111 0 1",
                     stall, flush_if_id, flush_id_ex);
        end
        tick();
        checks++;
        if (cnt_load_use !== 16'd1) begin
            errors++;
            $display("FAIL load_use_cnt: got %0d, want 1", cnt_load_use);
        end
        idle_inputs();
        apply();
        checks++;
        if (stall !== 6'b0) begin
            errors++;
            $display("FAIL load_use_after: got stall=%b, want 000000", stall);
        end
        tick();
    endtask

    task automatic test_x0_load();
        idle_inputs();
        ex_is_load = 1; ex_rd_enable = 1; ex_rd_addr = 0;
        id_reg2_read = 1; id_reg2_addr = 0;
        id_reg1_read = 1; id_reg1_addr = 0;
        apply();
        checks++;
        if ({stall, flush_if_id, flush_id_ex} !== 8'd0) begin
            errors++;
            $display("FAIL x0_load_ctrl: got stall=%b fii=%b fie=%b, want 0 0 0",
                     stall, flush_if_id, flush_id_ex);
        end
        tick();
        checks++;
        if (cnt_load_use !== 16'd1) begin
            errors++;
            $display("FAIL x0_load_cnt: got %0d, want 1", cnt_load_use);
        end
    endtask

    task automatic test_mispredict();
        idle_inputs();
        ex_mispredict = 1; ex_target = 32'h0000_1040;
        ex_is_load = 1; ex_rd_enable = 1; ex_rd_addr = 7; id_reg1_read = 1; id_reg1_addr = 7;
        apply();
        checks++;
        if ({redirect_valid, redirect_pc, flush_if_id, flush_id_ex, stall} !==
            {1'b1, 32'h0000_1040, 1'b1, 1'b1, 6'b0}) begin
            errors++;
            $display("FAIL mispredict_run: got rv=%b pc=%h fii=%b fie=%b stall=%b, want 1 00001040 1 1 000000",
                     redirect_valid, redirect_pc, flush_if_id, flush_id_ex, stall);
        end
        tick();
        ex_target = 32'h0000_2000;
        apply();
        checks++;
        if ({redirect_valid, flush_if_id, flush_id_ex, stall} !== 9'd0) begin
            errors++;
            $display("FAIL redirect_ignores: got rv=%b fii=%b fie=%b stall=%b, want all 0",
                     redirect_valid, flush_if_id, flush_id_ex, stall);
        end
        tick();
        checks++;
        if ({cnt_redirect, cnt_load_use} !== {16'd1, 16'd1}) begin
            errors++;
            $display("FAIL mispredict_cnt: got red=%0d lu=%0d, want 1 1", cnt_redirect, cnt_load_use);
        end
        idle_inputs();
        apply();
        tick();
    endtask

    task automatic test_stall_then_redirect();
        for (int i = 0; i < 3; i++) begin
            idle_inputs();
            mem_stall_req = 1;
            if (i == 0) begin ex_mispredict = 1; ex_target = 32'h200; end
            if (i == 1) begin ex_mispredict = 1; ex_target = 32'h300; end
            apply();
            checks++;
            if ({stall, redirect_valid} !== {6'b011111, 1'b0}) begin
                errors++;
                $display("FAIL mem_wait_%0d: got stall=%b rv=%b, want 011111 0", i, stall, redirect_valid);
            end
            tick();
        end
        idle_inputs();
        apply();
        checks++;
        if ({redirect_valid, redirect_pc, stall} !== {1'b1, 32'h200, 6'b0}) begin
            errors++;
            $display("FAIL pending_redirect: got rv=%b pc=%h stall=%b, want 1 00000200 000000",
                     redirect_valid, redirect_pc, stall);
        end
        tick();
        checks++;
        if ({cnt_mem_stall, cnt_redirect} !== {16'd3, 16'd2}) begin
            errors++;
            $display("FAIL stall_redirect_cnt: got mem=%0d red=%0d, want 3 2", cnt_mem_stall, cnt_redirect);
        end
        idle_inputs();
        apply();
        tick();
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        mem_stall_req = 1; ex_mispredict = 1; ex_target = 32'h0000_0ABC;
        apply();
        tick();
        ex_mispredict = 0;
        apply();
        rst = 0;
        #1;
        model_reset();
        checks++;
        if ({stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc,
             cnt_mem_stall, cnt_load_use, cnt_redirect} !== 89'd0) begin
            errors++;
            $display("FAIL reset_mid: got stall=%b rv=%b pc=%h cnt=%0d/%0d/%0d, want all 0",
                     stall, redirect_valid, redirect_pc, cnt_mem_stall, cnt_load_use, cnt_redirect);
        end
        @(posedge clk); #1;
        rst = 1;
        idle_inputs();
        apply();
        checks++;
        if ({redirect_valid, stall} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid_no_redirect: got rv=%b pc=%h stall=%b, want 0",
                     redirect_valid, redirect_pc, stall);
        end
        tick();
        checks++;
        if ({cnt_mem_stall, cnt_load_use, cnt_redirect} !== 48'd0) begin
            errors++;
            $display("FAIL reset_mid_cnt: got %0d %0d %0d, want 0 0 0",
                     cnt_mem_stall, cnt_load_use, cnt_redirect);
        end
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            id_reg1_read  = $urandom_range(0, 1);
            id_reg1_addr  = 5'($urandom_range(0, 3));
            id_reg2_read  = $urandom_range(0, 1);
            id_reg2_addr  = 5'($urandom_range(0, 3));
            ex_is_load    = ($urandom_range(0, 2) != 0);
            ex_rd_enable  = ($urandom_range(0, 3) != 0);
            ex_rd_addr    = 5'($urandom_range(0, 3));
            ex_mispredict = ($urandom_range(0, 5) == 0);
            ex_target     = $urandom() & 32'hFFFF_FFFC;
            if_stall_req  = ($urandom_range(0, 3) == 0);
            mem_stall_req = ($urandom_range(0, 3) == 0);
            apply();
            checks++;
            if ({stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc} !==
                {e_stall, e_fii, e_fie, e_rv, e_pc}) begin
                errors++;
                $display("FAIL rand_ctrl[%0d]: got stall=%b fii=%b fie=%b rv=%b pc=%h, want %b %b %b %b %h",
                         i, stall, flush_if_id, flush_id_ex, redirect_valid, redirect_pc,
                         e_stall, e_fii, e_fie, e_rv, e_pc);
            end
            checks++;
            if ({s_stall, s_flush_if_id, s_flush_id_ex, s_redirect_valid, s_redirect_pc} !==
                {e_stall, e_fii, e_fie, e_rv, e_pc}) begin
                errors++;
                $display("FAIL rand_ctrl_w4[%0d]: got stall=%b rv=%b pc=%h, want %b %b %h",
                         i, s_stall, s_redirect_valid, s_redirect_pc, e_stall, e_rv, e_pc);
            end
            tick();
            checks++;
            if ({cnt_mem_stall, cnt_load_use, cnt_redirect} !==
                {16'(m_cnt_mem), 16'(m_cnt_lu), 16'(m_cnt_red)}) begin
                errors++;
                $display("FAIL rand_cnt[%0d]: got %0d %0d %0d, want %0d %0d %0d", i,
                         cnt_mem_stall, cnt_load_use, cnt_redirect, m_cnt_mem, m_cnt_lu, m_cnt_red);
            end
            checks++;
            if ({s_cnt_mem_stall, s_cnt_load_use, s_cnt_redirect} !==
                {4'(m_cnt_mem4), 4'(m_cnt_lu4), 4'(m_cnt_red4)}) begin
                errors++;
                $display("FAIL rand_cnt_w4[%0d]: got %0d %0d %0d, want %0d %0d %0d", i,
                         s_cnt_mem_stall, s_cnt_load_use, s_cnt_redirect, m_cnt_mem4, m_cnt_lu4, m_cnt_red4);
            end
        end
    endtask

    task automatic test_saturation();
        idle_inputs();
        rst = 0;
        #1;
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        for (int i = 1; i <= 20; i++) begin
            mem_stall_req = 1;
            apply();
            tick();
            if (i == 14 || i == 15 || i == 17 || i == 20) begin
                checks++;
                if (s_cnt_mem_stall !== 4'(m_cnt_mem4)) begin
                    errors++;
                    $display("FAIL sat_cnt_w4[%0d]: got %0d, want %0d", i, s_cnt_mem_stall, m_cnt_mem4);
                end
            end
        end
        checks++;
        if ({s_cnt_mem_stall, cnt_mem_stall} !== {4'd15, 16'd20}) begin
            errors++;
            $display("FAIL sat_final: got w4=%0d w16=%0d, want 15 20", s_cnt_mem_stall, cnt_mem_stall);
        end
        idle_inputs();
        apply();
        tick();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0_load();
        test_mispredict();
        test_stall_then_redirect();
        test_reset_mid_stall();
        test_random(400);
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
